// File: rtl/noc_output_arbiter.sv
// Output-port stage of the mesh router: round-robin arbiter feeding a small FIFO.
// Optional per-input grant counters are enabled with `define NOC_ARB_GRANT_CNT_EN.
module noc_output_arbiter #(
    parameter int WIDTH_packet = 57,
    parameter int NUM_IN       = 4,
    parameter int DEPTH        = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_IN-1:0]              in_valid,
    input  logic [NUM_IN*WIDTH_packet-1:0] in_data,
    output logic [NUM_IN-1:0]              in_ready,
    output logic                           out_valid,
    output logic [WIDTH_packet-1:0]        out_data,
    input  logic                           out_ready,
`ifdef NOC_ARB_GRANT_CNT_EN
    output logic [$clog2(DEPTH):0]         occupancy,
    output logic [NUM_IN*16-1:0]           grant_cnt
`else
    output logic [$clog2(DEPTH):0]         occupancy
`endif
);

    localparam int IW = $clog2(NUM_IN);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH_packet-1:0] mem [DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           occ;
    logic [IW-1:0]           last_grant;

    logic [NUM_IN-1:0]       grant;
    logic [IW-1:0]           grant_idx;
    logic                    found;
    logic [WIDTH_packet-1:0] sel_data;
    logic                    full;
    logic                    push;
    logic                    pop;

    // Full is judged on the registered count only; a pop this cycle frees nothing.
    assign full      = (occ == CW'(DEPTH));
    assign out_valid = (occ != '0);
    assign out_data  = mem[rd_ptr];
    assign occupancy = occ;
    assign in_ready  = grant;
    assign push      = found;
    assign pop       = out_valid && out_ready;

    // Round-robin search starting just after the last input that transferred.
    always_comb begin
        int cand;
        logic [IW-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        idx       = '0;
        if (!rst && !full) begin
            for (int k = 1; k <= NUM_IN; k++) begin
                cand = int'(last_grant) + k;
                if (cand >= NUM_IN) begin
                    cand = cand - NUM_IN;
                end
                idx = IW'(cand);
                if (!found && in_valid[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    grant_idx  = idx;
                end
            end
        end
    end

    // Select the granted packet; the grant is one-hot so an OR-reduce suffices.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                sel_data = sel_data | in_data[i*WIDTH_packet +: WIDTH_packet];
            end
        end
    end

    // Pointers, fill count and arbitration history.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            last_grant <= IW'(NUM_IN - 1);
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + PW'(1);
                last_grant <= grant_idx;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Packet storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sel_data;
        end
    end

`ifdef NOC_ARB_GRANT_CNT_EN
    logic [15:0] cnt [NUM_IN];

    // Saturating accept counters, one per input.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (rst) begin
                cnt[i] <= '0;
            end else if (grant[i] && cnt[i] != 16'hFFFF) begin
                cnt[i] <= cnt[i] + 16'd1;
            end
        end
    end

    // Flatten the counters onto the output bus.
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            grant_cnt[i*16 +: 16] = cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Scoreboard bench for noc_output_arbiter.
// Also checks grant_cnt when NOC_ARB_GRANT_CNT_EN is defined.
module tb_noc_output_arbiter;

    localparam int W = 57;
    localparam int N = 4;
    localparam int D = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready;
    logic [2:0]     occupancy;
`ifdef NOC_ARB_GRANT_CNT_EN
    logic [N*16-1:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    noc_output_arbiter #(.WIDTH_packet(W), .NUM_IN(N), .DEPTH(D)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
`ifdef NOC_ARB_GRANT_CNT_EN
        .occupancy(occupancy),
        .grant_cnt(grant_cnt)
`else
        .occupancy(occupancy)
`endif
    );

    int n_err = 0;
    int n_checks = 0;

    int           m_last;
    int           m_occ;
    int           m_cnt [N];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] dut_out [$];
    logic [N-1:0] rdy_log [$];
    logic [N-1:0] seen_rdy;
    logic         src_v [N];
    logic [W-1:0] src_d [N];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive, check against model at negedge, update model at posedge.
    task automatic step();
        int g;
        int j;
        for (int i = 0; i < N; i++) begin
            in_valid[i]       = src_v[i];
            in_data[i*W +: W] = src_d[i];
        end
        @(negedge clk);
        g = -1;
        if (!rst && m_occ < D) begin
            for (int k = 1; k <= N; k++) begin
                j = (m_last + k) % N;
                if (g < 0 && src_v[j]) g = j;
            end
        end
        seen_rdy = in_ready;
        check("in_ready", in_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
        check("out_valid", out_valid, (m_occ != 0));
        check("occupancy", occupancy, m_occ);
        if (m_occ != 0) check("out_data", out_data, exp_q[0]);
`ifdef NOC_ARB_GRANT_CNT_EN
        for (int i = 0; i < N; i++)
            check("grant_cnt", grant_cnt[i*16 +: 16], m_cnt[i]);
`endif
        if (out_valid && out_ready) dut_out.push_back(out_data);
        @(posedge clk);
        if (rst) begin
            m_occ  = 0;
            m_last = N - 1;
            exp_q.delete();
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else begin
            if (m_occ > 0 && out_ready) void'(exp_q.pop_front());
            if (g >= 0) begin
                exp_q.push_back(src_d[g]);
                m_last = g;
                rdy_log.push_back(seen_rdy);
                if (m_cnt[g] < 65535) m_cnt[g]++;
            end
            m_occ = exp_q.size();
        end
        #1;
    endtask

    task automatic drop_accepted();
        for (int i = 0; i < N; i++)
            if (seen_rdy[i]) src_v[i] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < N; i++) src_v[i] = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 16 && m_occ != 0; c++) step();
        check("drained", occupancy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] rr_exp [6];
        int next;
        logic any;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        m_occ  = 0;
        m_last = N - 1;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            src_v[i] = 1'b1;
            src_d[i] = W'(i + 1);
        end
        rst       = 1'b1;
        out_ready = 1'b0;
        in_valid  = '1;
        in_data   = '0;
        @(posedge clk);
        #1;

        // Reset held with all inputs requesting.
        repeat (3) begin
            step();
            check("rst_rdy", seen_rdy, 0);
        end
        rst = 1'b0;
        step();
        check("first_grant", seen_rdy, 4'b0001);

        // Single pass-through.
        drain();
        src_v[2] = 1'b1;
        src_d[2] = 57'h0_1234_5678_9ABC;
        out_ready = 1'b1;
        dut_out.delete();
        step();
        check("pt_grant", seen_rdy, 4'b0100);
        drop_accepted();
        step();
        step();
        check("pt_occ", occupancy, 0);
        check("pt_cnt", dut_out.size(), 1);
        if (dut_out.size() > 0) check("pt_data", dut_out[0], 57'h0_1234_5678_9ABC);

        // Round-robin fairness with all producers re-presenting.
        do_reset();
        rdy_log.delete();
        out_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                src_v[i] = 1'b1;
                src_d[i] = W'(16 * (r + 1) + i);
            end
            step();
        end
        check("rr_count", rdy_log.size(), 6);
        for (int r = 0; r < 6 && r < rdy_log.size(); r++)
            check("rr_order", rdy_log[r], rr_exp[r]);

        // Backpressure until full, then release.
        drain();
        do_reset();
        dut_out.delete();
        out_ready = 1'b0;
        src_v[0] = 1'b1;
        src_v[1] = 1'b1;
        src_d[0] = 57'hA0;
        src_d[1] = 57'hA1;
        step();
        check("bp_g0", seen_rdy, 4'b0001);
        src_d[0] = 57'hB0;
        step();
        check("bp_g1", seen_rdy, 4'b0010);
        src_d[1] = 57'hB1;
        step();
        check("bp_full_rdy", seen_rdy, 0);
        check("bp_occ", occupancy, 2);
        out_ready = 1'b1;
        step();
        check("bp_pop1_rdy", seen_rdy, 0);
        step();
        check("bp_pops", dut_out.size(), 2);
        if (dut_out.size() >= 2) begin
            check("bp_first", dut_out[0], 57'hA0);
            check("bp_second", dut_out[1], 57'hA1);
        end

        // Ten tagged packets across pointer wrap with toggling out_ready.
        drain();
        dut_out.delete();
        next = 1;
        for (int c = 0; c < 200 && dut_out.size() < 10; c++) begin
            any = 1'b0;
            for (int i = 0; i < N; i++) any |= src_v[i];
            if (!any && next <= 10) begin
                src_v[(next - 1) % N] = 1'b1;
                src_d[(next - 1) % N] = W'(next);
                next++;
            end
            step();
            drop_accepted();
            out_ready = ~out_ready;
        end
        check("wrap_count", dut_out.size(), 10);
        for (int k = 0; k < 10 && k < dut_out.size(); k++)
            check("wrap_tag", dut_out[k], k + 1);

        // Reset while two packets are buffered.
        drain();
        do_reset();
        out_ready = 1'b0;
        src_v[0] = 1'b1;
        src_d[0] = 57'hDEAD1;
        step();
        drop_accepted();
        src_v[1] = 1'b1;
        src_d[1] = 57'hDEAD2;
        step();
        drop_accepted();
        check("mr_occ_pre", occupancy, 2);
        rst = 1'b1;
        step();
        check("mr_rdy", seen_rdy, 0);
        rst = 1'b0;
        check("mr_occ", occupancy, 0);
        check("mr_valid", out_valid, 0);
`ifdef NOC_ARB_GRANT_CNT_EN
        check("mr_gcnt", grant_cnt, 0);
`endif
        dut_out.delete();
        src_v[3] = 1'b1;
        src_d[3] = 57'hBEEF;
        out_ready = 1'b1;
        step();
        drop_accepted();
        step();
        step();
        check("mr_out_count", dut_out.size(), 1);
        if (dut_out.size() > 0) check("mr_out", dut_out[0], 57'hBEEF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
